// File: rtl/gaussian_conv_pkg.sv
// gaussian_conv_pkg
// Shared definitions for the Gaussian convolution MAC slice:
//   state_t    - controller state encoding (also exported on the debug port)
//   DEF_*      - default parameter values for SIZE, PIX_W and COEF_W
//   acc_width  - accumulator width that can hold SIZE*SIZE full-scale
//                pixel*coefficient products without overflow
package gaussian_conv_pkg;

   typedef enum logic [1:0] {
      ST_LOAD     = 2'd0,
      ST_WAIT_WIN = 2'd1,
      ST_MAC      = 2'd2,
      ST_OUTPUT   = 2'd3
   } state_t;

   localparam int DEF_SIZE   = 5;
   localparam int DEF_PIX_W  = 8;
   localparam int DEF_COEF_W = 16;

   // One product needs pix_w+coef_w bits; summing size*size of them adds
   // ceil(log2(size*size)) bits of headroom.
   function automatic int acc_width(input int pix_w, input int coef_w, input int size);
      return pix_w + coef_w + $clog2(size * size);
   endfunction

endpackage

// File: rtl/gaussian_coef_store.sv
// gaussian_coef_store
// Coefficient storage: DEPTH words of COEF_W bits, one synchronous write
// port and one combinational indexed read port. Contents are deliberately
// not reset; the controller tracks validity with coef_loaded.
// Ports:
//   clk      - rising-edge clock
//   wr_en    - write strobe
//   wr_idx   - write index
//   wr_data  - write word
//   rd_idx   - read index
//   rd_data  - word at rd_idx
module gaussian_coef_store #(
   parameter int DEPTH  = 25,
   parameter int COEF_W = 16,
   parameter int IDX_W  = 5
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [COEF_W-1:0] wr_data,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic [COEF_W-1:0] rd_data
);

   logic [COEF_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_idx] <= wr_data;
      end
   end

   assign rd_data = mem[rd_idx];

endmodule

// File: rtl/gaussian_conv_mac.sv
// gaussian_conv_mac
// SIZE x SIZE convolution of one pixel window against a loaded kernel using a
// single multiplier: one tap per cycle, SIZE*SIZE cycles per window, then the
// accumulator is rounded half-up from Q0.COEF_W back to a PIX_W pixel.
//
// Build option: define GAUSS_CONV_SAT_EN to clamp results above 2^PIX_W-1;
// without it the low PIX_W bits of the rounded result are output (wrap).
//
// Handshakes: a transfer happens on a rising edge where both valid and ready
// are high; valid/data are held by the sender until that edge, ready never
// depends on the same-cycle valid except that kernel_reload masks win_ready.
//
// Ports:
//   clk, reset_n          - clock, asynchronous active-low reset
//   kernel_reload         - restart coefficient loading (honoured in WAIT_WIN)
//   coef_valid/data/ready - coefficient stream, row-major order
//   coef_loaded           - all SIZE*SIZE coefficients held
//   win_valid/data/ready  - pixel window, element k at [k*PIX_W +: PIX_W]
//   out_valid/data/ready  - filtered pixel
//   dbg_state             - current controller state
module gaussian_conv_mac
   import gaussian_conv_pkg::*;
#(
   parameter int SIZE   = DEF_SIZE,
   parameter int PIX_W  = DEF_PIX_W,
   parameter int COEF_W = DEF_COEF_W
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       kernel_reload,
   input  logic                       coef_valid,
   input  logic [COEF_W-1:0]          coef_data,
   output logic                       coef_ready,
   output logic                       coef_loaded,
   input  logic                       win_valid,
   input  logic [SIZE*SIZE*PIX_W-1:0] win_data,
   output logic                       win_ready,
   output logic                       out_valid,
   output logic [PIX_W-1:0]           out_data,
   input  logic                       out_ready,
   output state_t                     dbg_state
);

   localparam int N      = SIZE * SIZE;
   localparam int IDX_W  = $clog2(N);
   localparam int ACC_W  = acc_width(PIX_W, COEF_W, SIZE);
   localparam int PROD_W = PIX_W + COEF_W;

   localparam logic [IDX_W-1:0] LAST     = IDX_W'(N - 1);
   localparam logic [ACC_W:0]   HALF     = (ACC_W+1)'(1) << (COEF_W - 1);
   localparam logic [ACC_W:0]   PIX_MAX  = (ACC_W+1)'((1 << PIX_W) - 1);

   state_t                     state;
   logic [IDX_W-1:0]           coef_idx;
   logic [IDX_W-1:0]           tap;
   logic [ACC_W-1:0]           acc;
   logic [N*PIX_W-1:0]         win_q;
   logic [COEF_W-1:0]          coef_rd;
   logic [PIX_W-1:0]           pix;
   logic [PROD_W-1:0]          prod;
   logic [ACC_W:0]             rnd_sum;
   logic [ACC_W:0]             result;
   logic                       coef_wr;
   logic                       win_take;

   // Reset holds the state at LOAD, so coef_ready is additionally gated by
   // reset_n to stay low while reset is asserted.
   assign coef_ready = reset_n && (state == ST_LOAD);
   assign win_ready  = (state == ST_WAIT_WIN) && !kernel_reload;
   assign out_valid  = (state == ST_OUTPUT);
   assign dbg_state  = state;

   assign coef_wr  = coef_valid && coef_ready;
   assign win_take = win_valid && win_ready;

   gaussian_coef_store #(
      .DEPTH  (N),
      .COEF_W (COEF_W),
      .IDX_W  (IDX_W)
   ) u_coef_store (
      .clk     (clk),
      .wr_en   (coef_wr),
      .wr_idx  (coef_idx),
      .wr_data (coef_data),
      .rd_idx  (tap),
      .rd_data (coef_rd)
   );

   // Datapath: one tap per cycle from the registered window.
   assign pix  = win_q[int'(tap) * PIX_W +: PIX_W];
   assign prod = PROD_W'(pix) * PROD_W'(coef_rd);

   // Round half up: add 0.5 LSB of the output scale, then drop the fraction.
   assign rnd_sum = {1'b0, acc} + HALF;
   assign result  = rnd_sum >> COEF_W;

   always_comb begin
      out_data = '0;
      if (state == ST_OUTPUT) begin
`ifdef GAUSS_CONV_SAT_EN
         out_data = (result > PIX_MAX) ? {PIX_W{1'b1}} : PIX_W'(result);
`else
         out_data = PIX_W'(result);
`endif
      end
   end

   // Window register has no reset: it is only read after a handshake loads it.
   always_ff @(posedge clk) begin
      if (win_take) begin
         win_q <= win_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= ST_LOAD;
         coef_idx    <= '0;
         tap         <= '0;
         acc         <= '0;
         coef_loaded <= 1'b0;
      end else begin
         case (state)
            ST_LOAD: begin
               // No timeout: the block waits here for as long as coef_valid is low.
               if (coef_wr) begin
                  if (coef_idx == LAST) begin
                     coef_loaded <= 1'b1;
                     coef_idx    <= '0;
                     state       <= ST_WAIT_WIN;
                  end else begin
                     coef_idx <= coef_idx + IDX_W'(1);
                  end
               end
            end
            ST_WAIT_WIN: begin
               if (kernel_reload) begin
                  coef_loaded <= 1'b0;
                  coef_idx    <= '0;
                  state       <= ST_LOAD;
               end else if (win_valid) begin
                  acc   <= '0;
                  tap   <= '0;
                  state <= ST_MAC;
               end
            end
            ST_MAC: begin
               acc <= acc + ACC_W'(prod);
               if (tap == LAST) begin
                  tap   <= '0;
                  state <= ST_OUTPUT;
               end else begin
                  tap <= tap + IDX_W'(1);
               end
            end
            ST_OUTPUT: begin
               if (out_ready) begin
                  state <= ST_WAIT_WIN;
               end
            end
            default: begin
               state <= ST_LOAD;
            end
         endcase
      end
   end

endmodule

// File: doc/gaussian_conv_mac.md
GAUSSIAN_CONV_MAC -- requirements
Module: gaussian_conv_mac

Interface
REQ-001 SHALL have parameter SIZE, default 5, the kernel and window edge length (odd, 3..7).
REQ-002 SHALL have parameter PIX_W, default 8, the pixel width (unsigned).
REQ-003 SHALL have parameter COEF_W, default 16, the coefficient width (unsigned Q0.COEF_W).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-005 SHALL have port reset_n, input, 1, the reset: asynchronous assert, active-low.
REQ-006 SHALL have port kernel_reload, input, 1, a pulse that restarts coefficient loading.
REQ-007 SHALL have port coef_valid, input, 1, a coefficient word is present.
REQ-008 SHALL have port coef_data, input, COEF_W, the coefficient in row-major (i, then j) order.
REQ-009 SHALL have port coef_ready, output, 1, the block accepts a coefficient.
REQ-010 SHALL have port coef_loaded, output, 1, all SIZE*SIZE coefficients are held.
REQ-011 SHALL have port win_valid, input, 1, a pixel window is present.
REQ-012 SHALL have port win_data, input, SIZE*SIZE*PIX_W, the row-major window; element k occupies bits [k*PIX_W +: PIX_W].
REQ-013 SHALL have port win_ready, output, 1, the block accepts a window.
REQ-014 SHALL have port out_valid, output, 1, the result is valid.
REQ-015 SHALL have port out_data, output, PIX_W, the filtered pixel.
REQ-016 SHALL have port out_ready, input, 1, the downstream side accepts the result.

Function
REQ-017 SHALL implement FSM states LOAD, WAIT_WIN, MAC and OUTPUT.
REQ-018 SHALL leave reset in LOAD.
REQ-019 SHALL assert coef_ready only in LOAD.
REQ-020 SHALL store each coef_valid&&coef_ready word at index coef_idx and then increment coef_idx.
REQ-021 SHALL, on acceptance of index SIZE*SIZE-1, set coef_loaded=1, clear coef_idx and go to WAIT_WIN on the next cycle.
REQ-022 SHALL assert win_ready only in WAIT_WIN.
REQ-023 SHALL, on a win_valid&&win_ready cycle, register the entire win_data, clear the accumulator and the tap counter, and enter MAC.
REQ-024 SHALL, in MAC, add pixel[tap]*coef[tap] to the accumulator once per cycle, which is exactly SIZE*SIZE cycles with one multiplier.
REQ-025 SHALL size the accumulator at ACC_W = PIX_W+COEF_W+$clog2(SIZE*SIZE) bits so that it never overflows.
REQ-026 SHALL enter OUTPUT after the last tap and compute result = (acc + 2^(COEF_W-1)) >> COEF_W, i.e. round half up.
REQ-027 SHALL assert out_valid in the cycle after the last tap, which is SIZE*SIZE+1 cycles after the window handshake.
REQ-028 SHALL hold out_valid and out_data stable until out_ready, then return to WAIT_WIN on the next cycle; out_ready outside OUTPUT has no effect.
REQ-029 SHALL honour kernel_reload only in WAIT_WIN: it clears coef_loaded and coef_idx and enters LOAD; in other states it is ignored.
REQ-030 SHALL give kernel_reload priority when it coincides with win_valid in WAIT_WIN: the window is not accepted (win_ready is forced to 0 that cycle).
REQ-031 SHALL, when coef_valid is low in LOAD, hold state without a timeout.

Reset
REQ-032 SHALL, while reset_n=0, set the state to LOAD and clear coef_idx, the tap counter, the accumulator and coef_loaded.
REQ-033 SHALL drive out_valid=0, out_data=0, coef_ready=0 (rising to 1 in the first cycle after release), and win_ready=0 during reset.
REQ-034 SHALL discard any partial load or in-flight MAC on reset assertion mid-operation, and SHALL NOT produce out_valid for it.
REQ-035 SHALL leave coefficient storage unreset; it is invalid until coef_loaded=1.

Configuration
REQ-036 SHALL, when GAUSS_CONV_SAT_EN is defined, saturate a result above 2^PIX_W-1 to 2^PIX_W-1.
REQ-037 SHALL, when GAUSS_CONV_SAT_EN is undefined, set out_data to the low PIX_W bits of the result (wrap).

Structure
REQ-038 SHALL take the state enum, the default widths and the ACC_W helper function from shared package gaussian_conv_pkg.
REQ-039 SHALL place coefficient storage in sub-module gaussian_coef_store: SIZE*SIZE x COEF_W, one write port, one indexed read port.

Verification
REQ-040 SHALL cover: load 25 x 0x0A3D, then a window of all 100 -> out_data=100 exactly 26 cycles after the window handshake.
REQ-041 SHALL cover: centre coefficient 0xFFFF with all others 0, and a window with centre 200 and others 0 -> out_data=200.
REQ-042 SHALL cover: 25 x 0xFFFF with a window of all 255 -> out_data=255 with GAUSS_CONV_SAT_EN, and 0xE7 without it.
REQ-043 SHALL cover: out_ready held low for 10 cycles -> out_valid and out_data stable and win_ready=0 throughout; one more cycle after out_ready rises, win_ready=1.
REQ-044 SHALL cover: kernel_reload together with win_valid in WAIT_WIN -> window not accepted, coef_loaded=0, coef_ready=1 on the next cycle.
REQ-045 SHALL cover: reset_n pulsed low during MAC tap 12 -> no out_valid, state LOAD, coef_loaded=0 after release.
